// File: rtl/delayed_link_fifo_pkg.sv
// Shared helpers for the delayed link FIFO.
// Countdown width is kept at least 1 bit so DELAY=1 still elaborates.
package delayed_link_fifo_pkg;

   function automatic int cnt_width(input int delay);
      return (delay > 1) ? $clog2(delay) : 1;
   endfunction

endpackage

// File: rtl/link_fifo_mem.sv
// Simple dual-port storage: synchronous write, asynchronous read.
// No reset; the controller never exposes an unwritten slot.
module link_fifo_mem #(
   parameter int WIDTH = 64,
   parameter int DEPTH = 128,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             we,
   input  logic [AW-1:0]    waddr,
   input  logic [WIDTH-1:0] wdata,
   input  logic [AW-1:0]    raddr,
   output logic [WIDTH-1:0] rdata
);

   logic [WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/delayed_link_fifo.sv
// Valid/ready FIFO holding each word at least DELAY cycles,
// modelling inter-FPGA link latency on a root-hub leaf channel.
module delayed_link_fifo
   import delayed_link_fifo_pkg::*;
#(
   parameter int WIDTH = 64,
   parameter int DEPTH = 128,
   parameter int DELAY = 3
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [WIDTH-1:0]         input_data,
   input  logic                     input_valid,
   output logic                     input_ready,
   output logic [WIDTH-1:0]         output_data,
   output logic                     output_valid,
   input  logic                     output_ready,
   output logic [$clog2(DEPTH):0]   occupancy
);

   localparam int AW = $clog2(DEPTH);
   localparam int OW = AW + 1;
   localparam int CW = cnt_width(DELAY);
   localparam logic [CW-1:0] LOAD = CW'(DELAY - 1);
   localparam logic [OW-1:0] FULL = OW'(DEPTH);

   generate
      if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || DELAY < 1) begin : g_bad
         $error("delayed_link_fifo: illegal DEPTH/DELAY");
      end
   endgenerate

   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [OW-1:0]    occ;
   logic [CW-1:0]    cnt [DEPTH];
   logic [WIDTH-1:0] rdata;
   logic             push;
   logic             pop;

   link_fifo_mem #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_mem (
      .clk   (clk),
      .we    (push),
      .waddr (wr_ptr),
      .wdata (input_data),
      .raddr (rd_ptr),
      .rdata (rdata)
   );

   // Ready depends only on stored state, never on output_ready.
   assign input_ready  = ~reset & (occ != FULL);
   assign output_valid = (occ != '0) & (cnt[rd_ptr] == '0);
   assign output_data  = output_valid ? rdata : '0;
   assign occupancy    = occ;

   assign push = input_valid & input_ready;
   assign pop  = output_valid & output_ready;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         occ    <= '0;
         for (int i = 0; i < DEPTH; i++) cnt[i] <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         unique case ({push, pop})
            2'b10:   occ <= occ + 1'b1;
            2'b01:   occ <= occ - 1'b1;
            default: ;
         endcase
         // Free slots sit at 0, so saturating every slot is harmless.
         for (int i = 0; i < DEPTH; i++) begin
            if (push && wr_ptr == AW'(i))
               cnt[i] <= LOAD;
            else if (cnt[i] != '0)
               cnt[i] <= cnt[i] - 1'b1;
         end
      end
   end

   a_no_push_full : assert property (@(posedge clk) disable iff (reset)
      !(push && occ == FULL));

   a_no_bad_pop : assert property (@(posedge clk) disable iff (reset)
      !(output_ready && !output_valid && pop));

   a_head_stable : assert property (@(posedge clk) disable iff (reset)
      (output_valid && !output_ready) |=> $stable(output_data));

endmodule

// File: tb/tb_delayed_link_fifo.sv
// Directed bench for delayed_link_fifo (DEPTH=4, DELAY=3).
// Inputs change 1 ns after each rising edge; outputs sampled there too.
module tb_delayed_link_fifo;

   localparam int WIDTH = 64;
   localparam int DEPTH = 4;
   localparam int DELAY = 3;

   logic             clk = 1'b0;
   logic             reset = 1'b1;
   logic [WIDTH-1:0] input_data = '0;
   logic             input_valid = 1'b0;
   logic             input_ready;
   logic [WIDTH-1:0] output_data;
   logic             output_valid;
   logic             output_ready = 1'b0;
   logic [2:0]       occupancy;

   int compared = 0;
   int mismatched = 0;

   delayed_link_fifo #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH),
      .DELAY (DELAY)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .input_data   (input_data),
      .input_valid  (input_valid),
      .input_ready  (input_ready),
      .output_data  (output_data),
      .output_valid (output_valid),
      .output_ready (output_ready),
      .occupancy    (occupancy)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      tick();
      compared++;
      if (input_ready !== 1'b0) begin
         mismatched++;
         $display("FAIL rst_in_ready: got %b want 0", input_ready);
      end
      compared++;
      if (output_valid !== 1'b0 || output_data !== '0) begin
         mismatched++;
         $display("FAIL rst_out: got v=%b d=%h want 0/0", output_valid, output_data);
      end
      compared++;
      if (occupancy !== 3'd0) begin
         mismatched++;
         $display("FAIL rst_occ: got %0d want 0", occupancy);
      end
      reset = 1'b0;
      tick();
      compared++;
      if (input_ready !== 1'b1) begin
         mismatched++;
         $display("FAIL rst_release_ready: got %b want 1", input_ready);
      end
   endtask

   task automatic test_single();
      output_ready = 1'b1;
      input_data = 64'h0000_0001_0000_00AB;
      input_valid = 1'b1;
      tick();
      input_valid = 1'b0;
      compared++;
      if (occupancy !== 3'd1 || output_valid !== 1'b0) begin
         mismatched++;
         $display("FAIL single_k: got occ=%0d v=%b want 1/0", occupancy, output_valid);
      end
      tick();
      compared++;
      if (output_valid !== 1'b0) begin
         mismatched++;
         $display("FAIL single_k1: got v=%b want 0", output_valid);
      end
      tick();
      compared++;
      if (output_valid !== 1'b1 || output_data !== 64'h0000_0001_0000_00AB) begin
         mismatched++;
         $display("FAIL single_k2: got v=%b d=%h want 1/00000001000000ab", output_valid, output_data);
      end
      tick();
      compared++;
      if (occupancy !== 3'd0 || output_valid !== 1'b0 || output_data !== '0) begin
         mismatched++;
         $display("FAIL single_k3: got occ=%0d v=%b d=%h want 0/0/0", occupancy, output_valid, output_data);
      end
   endtask

   task automatic test_back_to_back();
      logic [WIDTH-1:0] want;
      logic             vwant;
      output_ready = 1'b1;
      for (int j = 0; j < 11; j++) begin
         input_valid = (j < 8);
         input_data = (j < 8) ? WIDTH'(j + 1) : '0;
         tick();
         vwant = (j >= 2 && j <= 9);
         want = vwant ? WIDTH'(j - 1) : '0;
         compared++;
         if (output_valid !== vwant || output_data !== want) begin
            mismatched++;
            $display("FAIL b2b_%0d: got v=%b d=%h want %b/%h", j, output_valid, output_data, vwant, want);
         end
      end
      input_valid = 1'b0;
      compared++;
      if (occupancy !== 3'd0) begin
         mismatched++;
         $display("FAIL b2b_occ: got %0d want 0", occupancy);
      end
   endtask

   task automatic test_full();
      logic [WIDTH-1:0] seq [4] = '{64'd2, 64'd3, 64'd4, 64'd5};
      output_ready = 1'b0;
      input_valid = 1'b1;
      for (int i = 1; i <= 5; i++) begin
         input_data = WIDTH'(i);
         if (i <= 4) tick();
      end
      compared++;
      if (input_ready !== 1'b0 || occupancy !== 3'd4) begin
         mismatched++;
         $display("FAIL full_ready: got rdy=%b occ=%0d want 0/4", input_ready, occupancy);
      end
      tick();
      compared++;
      if (occupancy !== 3'd4 || output_data !== 64'd1) begin
         mismatched++;
         $display("FAIL full_hold: got occ=%0d d=%h want 4/1", occupancy, output_data);
      end
      output_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         if (i == 1) input_valid = 1'b0;
         if (i == 0) begin
            compared++;
            if (input_ready !== 1'b1 || occupancy !== 3'd3) begin
               mismatched++;
               $display("FAIL full_reopen: got rdy=%b occ=%0d want 1/3", input_ready, occupancy);
            end
         end
         compared++;
         if (output_valid !== 1'b1 || output_data !== seq[i]) begin
            mismatched++;
            $display("FAIL full_drain_%0d: got v=%b d=%h want 1/%h", i, output_valid, output_data, seq[i]);
         end
      end
      tick();
      compared++;
      if (occupancy !== 3'd0 || output_valid !== 1'b0) begin
         mismatched++;
         $display("FAIL full_empty: got occ=%0d v=%b want 0/0", occupancy, output_valid);
      end
   endtask

   task automatic test_stall();
      int bad = 0;
      output_ready = 1'b0;
      input_valid = 1'b1;
      input_data = 64'hA5A5;
      tick();
      input_data = 64'h5A5A;
      tick();
      input_valid = 1'b0;
      tick();
      for (int i = 0; i < 300; i++) begin
         if (output_valid !== 1'b1 || output_data !== 64'hA5A5) bad++;
         tick();
      end
      compared++;
      if (bad != 0) begin
         mismatched++;
         $display("FAIL stall_head: got %0d bad cycles want 0", bad);
      end
      compared++;
      if (occupancy !== 3'd2) begin
         mismatched++;
         $display("FAIL stall_occ: got %0d want 2", occupancy);
      end
      output_ready = 1'b1;
      tick();
      compared++;
      if (output_valid !== 1'b1 || output_data !== 64'h5A5A) begin
         mismatched++;
         $display("FAIL stall_second: got v=%b d=%h want 1/5a5a", output_valid, output_data);
      end
      tick();
      compared++;
      if (occupancy !== 3'd0) begin
         mismatched++;
         $display("FAIL stall_empty: got %0d want 0", occupancy);
      end
   endtask

   task automatic test_simul();
      output_ready = 1'b0;
      input_valid = 1'b1;
      input_data = 64'h11;
      tick();
      input_data = 64'h22;
      tick();
      input_valid = 1'b0;
      tick();
      tick();
      output_ready = 1'b1;
      input_valid = 1'b1;
      input_data = 64'h33;
      tick();
      input_valid = 1'b0;
      compared++;
      if (occupancy !== 3'd2 || output_data !== 64'h22) begin
         mismatched++;
         $display("FAIL simul_occ: got occ=%0d d=%h want 2/22", occupancy, output_data);
      end
      tick();
      compared++;
      if (occupancy !== 3'd1 || output_valid !== 1'b0) begin
         mismatched++;
         $display("FAIL simul_wait: got occ=%0d v=%b want 1/0", occupancy, output_valid);
      end
      tick();
      compared++;
      if (output_valid !== 1'b1 || output_data !== 64'h33) begin
         mismatched++;
         $display("FAIL simul_new: got v=%b d=%h want 1/33", output_valid, output_data);
      end
      tick();
      compared++;
      if (occupancy !== 3'd0) begin
         mismatched++;
         $display("FAIL simul_empty: got %0d want 0", occupancy);
      end
   endtask

   task automatic test_reset_mid();
      output_ready = 1'b0;
      input_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         input_data = WIDTH'(64'hC0 + i);
         tick();
      end
      input_valid = 1'b0;
      tick();
      #2;
      reset = 1'b1;
      #1;
      compared++;
      if (output_valid !== 1'b0 || occupancy !== 3'd0 || input_ready !== 1'b0) begin
         mismatched++;
         $display("FAIL midrst: got v=%b occ=%0d rdy=%b want 0/0/0", output_valid, occupancy, input_ready);
      end
      tick();
      reset = 1'b0;
      tick();
      compared++;
      if (input_ready !== 1'b1 || occupancy !== 3'd0) begin
         mismatched++;
         $display("FAIL midrst_release: got rdy=%b occ=%0d want 1/0", input_ready, occupancy);
      end
      output_ready = 1'b1;
      input_valid = 1'b1;
      input_data = 64'h77;
      tick();
      input_valid = 1'b0;
      tick();
      compared++;
      if (output_valid !== 1'b0 || occupancy !== 3'd1) begin
         mismatched++;
         $display("FAIL midrst_wait: got v=%b occ=%0d want 0/1", output_valid, occupancy);
      end
      tick();
      compared++;
      if (output_valid !== 1'b1 || output_data !== 64'h77) begin
         mismatched++;
         $display("FAIL midrst_word: got v=%b d=%h want 1/77", output_valid, output_data);
      end
      tick();
      compared++;
      if (occupancy !== 3'd0 || output_valid !== 1'b0) begin
         mismatched++;
         $display("FAIL midrst_empty: got occ=%0d v=%b want 0/0", occupancy, output_valid);
      end
   endtask

   initial begin
      #1;
      test_reset();
      test_single();
      test_back_to_back();
      test_full();
      test_stall();
      test_simul();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
